// File: rtl/act_feeder_if.sv
// Bundles the UB read-burst bus and the systolic-array activation bus of act_feeder.
// master = feeder side, slave = unified buffer / array side.
interface act_feeder_if #(
  parameter int DATA_WIDTH = 256,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  ub_rd_en;
  logic [ADDR_WIDTH:0]   ub_rd_addr;
  logic [ADDR_WIDTH:0]   ub_rd_count;
  logic [DATA_WIDTH-1:0] ub_rd_data;
  logic                  ub_rd_valid;
  logic                  sa_ready;
  logic [DATA_WIDTH-1:0] sa_act;
  logic [LANES-1:0]      sa_valid;

  modport master (
    output ub_rd_en, ub_rd_addr, ub_rd_count, sa_act, sa_valid,
    input  ub_rd_data, ub_rd_valid, sa_ready
  );

  modport slave (
    input  ub_rd_en, ub_rd_addr, ub_rd_count, sa_act, sa_valid,
    output ub_rd_data, ub_rd_valid, sa_ready
  );
endinterface

// File: rtl/act_feeder.sv
// Activation feeder: fetches UB words in credit-checked sub-bursts, buffers them and feeds the array.
// Define ACT_FEEDER_SKEW_EN for diagonal lane skew; default build presents all lanes together.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | waiting for FIFO room, then issues one sub-burst read
// WAIT  | collecting the beats of the current sub-burst
// DRAIN | all words fetched, waiting for FIFO and output pipeline to empty
module act_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] base_addr,
  input  logic [ADDR_WIDTH:0] row_count,
  output logic                busy,
  output logic                done,
  output logic                err_overrun,
  act_feeder_if.master        bus
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [AW1-1:0] DEPTH_A = AW1'(FIFO_DEPTH);
  localparam logic [AW1-1:0] ONE_A   = AW1'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t                state;
  logic [AW1-1:0]        cur_addr, remaining, chunk_r, beat_cnt;
  logic [AW1-1:0]        chunk, free_cnt;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  push, pop, fifo_empty, pipe_busy;
  logic [DATA_WIDTH-1:0] stage_in;
  logic [DATA_WIDTH-1:0] act_o;
  logic [LANES-1:0]      valid_o;

  assign chunk      = (remaining < DEPTH_A) ? remaining : DEPTH_A;
  assign free_cnt   = DEPTH_A - AW1'(fifo_cnt);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = (state == WAIT) && bus.ub_rd_valid && (beat_cnt < chunk_r);
  assign pop        = bus.sa_ready && !fifo_empty;
  assign stage_in   = pop ? fifo_mem[rd_ptr] : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cur_addr        <= '0;
      remaining       <= '0;
      chunk_r         <= '0;
      beat_cnt        <= '0;
      bus.ub_rd_en    <= 1'b0;
      bus.ub_rd_addr  <= '0;
      bus.ub_rd_count <= '0;
      done            <= 1'b0;
      err_overrun     <= 1'b0;
    end else begin
      bus.ub_rd_en <= 1'b0;
      done         <= 1'b0;
      // IDLE beats are dropped silently so stale traffic after a reset is harmless
      if (bus.ub_rd_valid && ((state == REQ) || (state == DRAIN) ||
                              ((state == WAIT) && (beat_cnt >= chunk_r))))
        err_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            err_overrun <= 1'b0;
            if (row_count != '0) begin
              cur_addr  <= base_addr;
              remaining <= row_count;
              state     <= REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        REQ: begin
          if (free_cnt >= chunk) begin
            bus.ub_rd_en    <= 1'b1;
            bus.ub_rd_addr  <= cur_addr;
            bus.ub_rd_count <= chunk;
            cur_addr        <= cur_addr + chunk;
            remaining       <= remaining - chunk;
            chunk_r         <= chunk;
            beat_cnt        <= '0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (push) begin
            beat_cnt <= beat_cnt + ONE_A;
            if (beat_cnt + ONE_A == chunk_r)
              state <= (remaining == '0) ? DRAIN : REQ;
          end
        end
        DRAIN: begin
          if (fifo_empty && !pipe_busy) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.ub_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef ACT_FEEDER_SKEW_EN
  logic [LANES-1:0] lane_busy;

  // lane i rides an (i+1)-deep shift line; the oldest slot is what the array sees
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [(i+1)*LANE_WIDTH-1:0] d_q;
    logic [i:0]                  v_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d_q <= '0;
        v_q <= '0;
      end else if (bus.sa_ready) begin
        d_q <= (d_q << LANE_WIDTH) |
               ((i+1)*LANE_WIDTH)'(stage_in[i*LANE_WIDTH +: LANE_WIDTH]);
        v_q <= (v_q << 1) | (i+1)'(pop);
      end
    end

    assign act_o[i*LANE_WIDTH +: LANE_WIDTH] = d_q[i*LANE_WIDTH +: LANE_WIDTH];
    assign valid_o[i]   = v_q[i];
    assign lane_busy[i] = |v_q;
  end

  assign pipe_busy = |lane_busy;
`else
  logic [DATA_WIDTH-1:0] act_q;
  logic                  v_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q <= '0;
      v_q   <= 1'b0;
    end else if (bus.sa_ready) begin
      act_q <= stage_in;
      v_q   <= pop;
    end
  end

  assign act_o     = act_q;
  assign valid_o   = {LANES{v_q}};
  assign pipe_busy = v_q;
`endif

  assign bus.sa_act   = act_o;
  assign bus.sa_valid = valid_o;
endmodule

// File: tb/tb_act_feeder.sv
// Self-checking bench for act_feeder: random UB data and sa_ready against a word-queue/history model.
module tb_act_feeder;
  localparam int DW    = 256;
  localparam int LW    = 8;
  localparam int AW    = 8;
  localparam int FD    = 4;
  localparam int LANES = DW / LW;
  localparam int AW1   = AW + 1;
  localparam int MEMW  = 1 << AW1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   base_addr = '0;
  logic [AW:0]   row_count = '0;
  logic          busy, done, err_overrun;

  act_feeder_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  act_feeder #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .row_count(row_count),
    .busy(busy), .done(done), .err_overrun(err_overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic [DW-1:0] ub_mem [MEMW];
  int  pend_addr[$];
  bit  pend_legit[$];
  bit  beat_legit = 1'b0;
  bit  inject_extra = 1'b0;
  bit  resp_nogap = 1'b0;
  int  burst_addr[$];
  int  burst_cnt[$];

  // reference: words accepted into the feeder, and the last LANES advanced words (0 = newest)
  logic [DW-1:0] mq[$];
  logic [DW-1:0] hist_d [LANES];
  bit            hist_v [LANES];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        for (int i = 0; i < LANES; i++) begin
          hist_d[i] = '0;
          hist_v[i] = 1'b0;
        end
      end else begin
        if (bus.sa_ready) begin
          for (int i = LANES - 1; i > 0; i--) begin
            hist_d[i] = hist_d[i-1];
            hist_v[i] = hist_v[i-1];
          end
          if (mq.size() > 0) begin
            hist_d[0] = mq.pop_front();
            hist_v[0] = 1'b1;
          end else begin
            hist_d[0] = '0;
            hist_v[0] = 1'b0;
          end
        end
        if (bus.ub_rd_valid && beat_legit) mq.push_back(bus.ub_rd_data);
      end
    end
  end

  // unified-buffer responder: logs each read request and returns its beats with random gaps
  initial begin
    int a, c;
    bus.ub_rd_valid = 1'b0;
    bus.ub_rd_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n)
        for (int k = 0; k < pend_legit.size(); k++) pend_legit[k] = 1'b0;
      if (bus.ub_rd_en === 1'b1) begin
        a = int'(bus.ub_rd_addr);
        c = int'(bus.ub_rd_count);
        burst_addr.push_back(a);
        burst_cnt.push_back(c);
        chk("credit", DW'(mq.size() + c <= FD), DW'(1));
        for (int k = 0; k < c; k++) begin
          pend_addr.push_back((a + k) % MEMW);
          pend_legit.push_back(1'b1);
        end
        if (inject_extra) begin
          pend_addr.push_back((a + c) % MEMW);
          pend_legit.push_back(1'b0);
          inject_extra = 1'b0;
        end
      end
      if (pend_addr.size() > 0 && (resp_nogap || $urandom_range(0, 3) != 0)) begin
        bus.ub_rd_valid = 1'b1;
        bus.ub_rd_data  = ub_mem[pend_addr.pop_front()];
        beat_legit      = pend_legit.pop_front();
      end else begin
        bus.ub_rd_valid = 1'b0;
        bus.ub_rd_data  = {8{$urandom}};
        beat_legit      = 1'b0;
      end
    end
  end

  task automatic tick(input bit rdy);
    logic [DW-1:0]    ea;
    logic [LANES-1:0] ev;
    @(negedge clk);
    ea = '0;
    ev = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef ACT_FEEDER_SKEW_EN
      ea[i*LW +: LW] = hist_d[i][i*LW +: LW];
      ev[i]          = hist_v[i];
`else
      ea[i*LW +: LW] = hist_d[0][i*LW +: LW];
      ev[i]          = hist_v[0];
`endif
    end
    chk("sa_act", bus.sa_act, ea);
    chk("sa_valid", DW'(bus.sa_valid), DW'(ev));
    if (done === 1'b1) begin
      done_seen++;
      chk("valid_at_done", DW'(bus.sa_valid), '0);
    end
    bus.sa_ready = rdy;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
    chk({tag, "_err"}, DW'(err_overrun), '0);
    chk({tag, "_rd_en"}, DW'(bus.ub_rd_en), '0);
    chk({tag, "_rd_addr"}, DW'(bus.ub_rd_addr), '0);
    chk({tag, "_rd_count"}, DW'(bus.ub_rd_count), '0);
    chk({tag, "_act"}, bus.sa_act, '0);
    chk({tag, "_valid"}, DW'(bus.sa_valid), '0);
  endtask

  task automatic run_job(input int base, input int rows, input int stall_at,
                         input bit rnd_ready, input bit poke_start, input bit exp_err);
    int ea[$];
    int ec[$];
    int rem, a, c, cyc;
    bit rdy;
    rem = rows;
    a   = base;
    while (rem > 0) begin
      c = (rem < FD) ? rem : FD;
      ea.push_back(a);
      ec.push_back(c);
      a   = (a + c) % MEMW;
      rem = rem - c;
    end
    burst_addr.delete();
    burst_cnt.delete();
    done_seen = 0;
    start     = 1'b1;
    base_addr = AW1'(base);
    row_count = AW1'(rows);
    tick(1'b1);
    start = 1'b0;
    cyc   = 0;
    while (done_seen == 0 && cyc < 3000) begin
      start = 1'b0;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 20) rdy = 1'b0;
      else if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      if (poke_start && cyc == 5) begin
        start     = 1'b1;
        base_addr = 9'h0AA;
        row_count = 9'd7;
      end
      tick(rdy);
      cyc++;
    end
    start = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("done_count", DW'(done_seen), DW'(1));
    chk("busy_after", DW'(busy), '0);
    chk("err_flag", DW'(err_overrun), DW'(exp_err));
    chk("burst_n", DW'(burst_addr.size()), DW'(ea.size()));
    for (int k = 0; k < ea.size(); k++) begin
      if (k < burst_addr.size()) begin
        chk("burst_addr", DW'(burst_addr[k]), DW'(ea[k]));
        chk("burst_cnt", DW'(burst_cnt[k]), DW'(ec[k]));
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEMW; i++) ub_mem[i] = {8{$urandom}};
    bus.sa_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick(1'b0);
    check_reset("rst");
    rst_n = 1'b1;
    tick(1'b1);

    run_job(16, 3, -1, 1'b0, 1'b0, 1'b0);
    run_job(0, 10, -1, 1'b1, 1'b1, 1'b0);
    run_job(9'h1FE, 4, -1, 1'b1, 1'b0, 1'b0);
    run_job(9'h1FE, 6, -1, 1'b1, 1'b0, 1'b0);
    run_job(64, 10, 3, 1'b0, 1'b0, 1'b0);

    resp_nogap   = 1'b1;
    inject_extra = 1'b1;
    run_job(128, 2, -1, 1'b0, 1'b0, 1'b1);
    resp_nogap   = 1'b0;

    burst_addr.delete();
    burst_cnt.delete();
    start     = 1'b1;
    base_addr = 9'd5;
    row_count = '0;
    tick(1'b1);
    start = 1'b0;
    chk("zero_done", DW'(done), DW'(1));
    tick(1'b1);
    chk("zero_done_once", DW'(done), '0);
    chk("zero_idle", DW'(busy), '0);
    tick(1'b1);
    chk("zero_no_burst", DW'(burst_addr.size()), '0);

    run_job(200, 5, -1, 1'b1, 1'b0, 1'b0);

    burst_addr.delete();
    burst_cnt.delete();
    done_seen = 0;
    start     = 1'b1;
    base_addr = 9'h100;
    row_count = 9'd8;
    tick(1'b1);
    start = 1'b0;
    n = 0;
    while (burst_addr.size() == 0 && n < 50) begin
      tick(1'b1);
      n++;
    end
    chk("wait_reached", DW'(burst_addr.size()), DW'(1));
    rst_n = 1'b0;
    tick(1'b1);
    check_reset("midrst");
    tick(1'b1);
    rst_n = 1'b1;
    n = 0;
    while (pend_addr.size() > 0 && n < 100) begin
      tick(1'b1);
      n++;
    end
    tick(1'b1);
    tick(1'b1);
    chk("no_done_rst", DW'(done_seen), '0);
    chk("pend_drained", DW'(pend_addr.size()), '0);
    chk("stale_err", DW'(err_overrun), '0);
    chk("stale_busy", DW'(busy), '0);

    run_job(300, 1, -1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
